// File: rtl/axis_write_ctrl.sv
// axis_write_ctrl: splits a stream write command into AXI write bursts and tracks B responses
module axis_write_ctrl #(
  parameter int CONFIG_DWIDTH   = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int CONVERT_SHIFT   = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_DWIDTH-1:0]  cmd_address,
  input  logic [CONFIG_DWIDTH-1:0]  cmd_length,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  output logic                      done,
  output logic                      error,
  output logic [CONFIG_DWIDTH-1:0]  data_cfg_length,
  output logic                      data_cfg_valid,
  input  logic                      data_cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CONFIG_DWIDTH-1:0] FULL = CONFIG_DWIDTH'(1) << AXI_LEN_WIDTH;
  typedef enum logic [2:0] {IDLE, CFG, SETUP, ADDR, RESP, DONE} state_t;
  state_t                    state_q;
  logic [CONFIG_DWIDTH-1:0]  addr_q, len_q, beats_q, burst, step;
  logic [OW-1:0]             out_q;
  logic                      err_q, aw_hs, b_dec;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_LEN_WIDTH-1:0]  awlen_q;
  assign cmd_ready       = ~rst & (state_q == IDLE);
  assign axi_bready      = ~rst;
  assign data_cfg_valid  = state_q == CFG;
  assign data_cfg_length = len_q;
  assign axi_awvalid     = (state_q == ADDR) & (out_q != OW'(MAX_OUTSTANDING));
  assign axi_awaddr      = awaddr_q;
  assign axi_awlen       = awlen_q;
  assign done            = state_q == DONE;
  assign error           = done & err_q;
  assign aw_hs           = axi_awvalid & axi_awready;
  assign b_dec           = axi_bvalid & axi_bready & (out_q != '0);
  assign burst           = CONFIG_DWIDTH'(awlen_q) + CONFIG_DWIDTH'(1);
  assign step            = burst * CONFIG_DWIDTH'(AXI_DATA_WIDTH / 8);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      out_q <= out_q + OW'(aw_hs) - OW'(b_dec);
      if (b_dec && axi_bresp != 2'b00) err_q <= 1'b1;
      case (state_q)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_address;
          len_q   <= cmd_length;
          beats_q <= cmd_length >> CONVERT_SHIFT;
          err_q   <= 1'b0;
          out_q   <= '0;
          state_q <= CFG;
        end
        CFG: if (data_cfg_ready) state_q <= SETUP;
        SETUP: begin
          awaddr_q <= AXI_ADDR_WIDTH'(addr_q);
          awlen_q  <= AXI_LEN_WIDTH'((beats_q < FULL ? beats_q : FULL) - CONFIG_DWIDTH'(1));
          state_q  <= ADDR;
        end
        ADDR: if (aw_hs) begin
          beats_q <= beats_q - burst;
          addr_q  <= addr_q + step;
          state_q <= beats_q == burst ? RESP : SETUP;
        end
        RESP: if (out_q == '0) state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_write_ctrl.sv
// tb_axis_write_ctrl: directed table-driven and sequence checks for axis_write_ctrl
module tb_axis_write_ctrl;
  logic        clk = 0, rst = 1;
  logic [31:0] cmd_address = 0, cmd_length = 0;
  logic        cmd_valid = 0, cmd_ready, done, error;
  logic [31:0] data_cfg_length;
  logic        data_cfg_valid, data_cfg_ready = 0;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid, axi_awready = 0;
  logic [1:0]  axi_bresp = 0;
  logic        axi_bvalid = 0, axi_bready;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          bad;
    int          cfg_stall;
    int          aw_stall;
    int          nb;
    logic        err;
  } vec_t;
  vec_t tbl[6];
  axis_write_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .error(error),
    .data_cfg_length(data_cfg_length), .data_cfg_valid(data_cfg_valid), .data_cfg_ready(data_cfg_ready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic start_cmd(input logic [31:0] a, input logic [31:0] l);
    for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_address = a;
    cmd_length = l;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic take_aw(input logic [31:0] ea, input logic [31:0] el, input bit sim_b);
    bit seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (axi_awvalid) seen = 1;
      else @(negedge clk);
    end
    chk("aw_seen", 32'(seen), 1);
    if (seen) begin
      chk("awaddr", axi_awaddr, ea);
      chk("awlen", 32'(axi_awlen), el);
      axi_awready = 1;
      axi_bvalid = sim_b;
      axi_bresp = 0;
      @(negedge clk);
      axi_awready = 0;
      axi_bvalid = 0;
    end
  endtask
  task automatic send_b(input logic [1:0] r);
    axi_bvalid = 1;
    axi_bresp = r;
    @(negedge clk);
    axi_bvalid = 0;
  endtask
  task automatic wait_done(input logic exp_err);
    for (int i = 0; i < 8 && !done; i++) @(negedge clk);
    chk("done_seen", 32'(done), 1);
    chk("done_error", 32'(error), 32'(exp_err));
  endtask
  task automatic run_cmd(input vec_t v);
    int rem, exl, nb, cfg_cnt, aw_cnt;
    logic [31:0] ea;
    logic [1:0] q[$];
    bit fin, pend;
    rem = int'(v.len >> 3);
    ea = v.addr;
    nb = 0; cfg_cnt = 0; aw_cnt = 0; fin = 0; pend = 0;
    start_cmd(v.addr, v.len);
    for (int c = 0; c < 3000 && !fin; c++) begin
      axi_bvalid = 0;
      axi_awready = 0;
      data_cfg_ready = 0;
      if (done) begin
        fin = 1;
        chk("burst_count", nb, v.nb);
        chk("b_drained", q.size(), 0);
        chk("error", 32'(error), 32'(v.err));
        chk("cmd_ready_in_done", 32'(cmd_ready), 0);
      end else begin
        if (pend) chk("cfg_valid_held", 32'(data_cfg_valid), 1);
        if (data_cfg_valid) begin
          chk("cfg_length", data_cfg_length, v.len);
          if (axi_awvalid) chk("aw_during_cfg", 32'(axi_awvalid), 0);
          data_cfg_ready = cfg_cnt >= v.cfg_stall;
          pend = !data_cfg_ready;
          cfg_cnt++;
        end else pend = 0;
        if (q.size() > 0) begin
          axi_bvalid = 1;
          axi_bresp = q.pop_front();
        end
        if (axi_awvalid) begin
          exl = (rem < 256 ? rem : 256) - 1;
          chk("awaddr", axi_awaddr, ea);
          chk("awlen", 32'(axi_awlen), exl);
          if (aw_cnt >= v.aw_stall) begin
            axi_awready = 1;
            ea = ea + 32'((exl + 1) * 4);
            rem = rem - (exl + 1);
            q.push_back(nb == v.bad ? 2'b10 : 2'b00);
            nb++;
            aw_cnt = 0;
          end else aw_cnt++;
        end
        @(negedge clk);
      end
    end
    axi_bvalid = 0;
    axi_awready = 0;
    data_cfg_ready = 0;
    chk("cmd_completed", 32'(fin), 1);
  endtask
  initial begin
    tbl[0] = '{32'h1000, 32'd80,   -1, 0, 0, 1, 1'b0};
    tbl[1] = '{32'h1000, 32'd4160, -1, 0, 0, 3, 1'b0};
    tbl[2] = '{32'h2000, 32'd80,   -1, 0, 5, 1, 1'b0};
    tbl[3] = '{32'h3000, 32'd2048, -1, 3, 0, 1, 1'b0};
    tbl[4] = '{32'h4000, 32'd4160,  1, 0, 0, 3, 1'b1};
    tbl[5] = '{32'h4000, 32'd4160, -1, 0, 0, 3, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_bready", 32'(axi_bready), 0);
    chk("rst_awvalid", 32'(axi_awvalid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cfg_valid", 32'(data_cfg_valid), 0);
    chk("rst_awaddr", axi_awaddr, 0);
    chk("rst_awlen", 32'(axi_awlen), 0);
    rst = 0;
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("idle_bready", 32'(axi_bready), 1);
    @(negedge clk);
    send_b(2'b10);
    chk("stray_b_no_done", 32'(done), 0);
    for (int i = 0; i < 6; i++) run_cmd(tbl[i]);
    data_cfg_ready = 1;
    start_cmd(32'h8000, 32'd8192);
    take_aw(32'h8000, 255, 0);
    take_aw(32'h8400, 255, 0);
    for (int i = 0; i < 6; i++) begin
      chk("aw_stall_full", 32'(axi_awvalid), 0);
      @(negedge clk);
    end
    send_b(2'b00);
    take_aw(32'h8800, 255, 1);
    take_aw(32'h8C00, 255, 0);
    chk("resp_wait_done", 32'(done), 0);
    send_b(2'b00);
    chk("resp_wait_done2", 32'(done), 0);
    send_b(2'b00);
    wait_done(1'b0);
    @(negedge clk);
    start_cmd(32'hA000, 32'd4160);
    take_aw(32'hA000, 255, 0);
    for (int i = 0; i < 5 && !axi_awvalid; i++) @(negedge clk);
    chk("mid_awvalid", 32'(axi_awvalid), 1);
    rst = 1;
    #1;
    chk("mid_rst_bready", 32'(axi_bready), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_awvalid", 32'(axi_awvalid), 0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_cfg_valid", 32'(data_cfg_valid), 0);
    chk("post_rst_awaddr", axi_awaddr, 0);
    run_cmd(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
